// File: rtl/mem_line_responder_if.sv
// Memory port between the core's L1 miss path (master) and the line responder (slave).
interface mem_line_responder_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned OpmW  = 5;
  localparam int unsigned LineW = 128;
  localparam int unsigned OkW   = 2;

  logic [AddrW-1:0] memAddr;
  logic [OpmW-1:0]  memOpm;
  logic [LineW-1:0] memDataOut;
  logic [LineW-1:0] memDataIn;
  logic [OkW-1:0]   memOK;

  modport master (
    output memAddr,
    output memOpm,
    output memDataOut,
    input  memDataIn,
    input  memOK
  );

  modport slave (
    input  memAddr,
    input  memOpm,
    input  memDataOut,
    output memDataIn,
    output memOK
  );
endinterface

// File: rtl/mem_line_responder.sv
// Main-memory stand-in: services 128-bit line reads/writes from an internal RAM
// with a programmable number of HOLD cycles before OK.
module mem_line_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clock,
  input logic            reset,
  mem_line_responder_if.slave bus
);
  localparam int unsigned CntW  = 4;
  localparam int unsigned LineW = 128;
  localparam int unsigned AddrW = 32;
  localparam int unsigned Lines = 1 << ADDR_BITS;

  localparam logic [1:0] OkReady = 2'b00;
  localparam logic [1:0] OkDone  = 2'b01;
  localparam logic [1:0] OkHold  = 2'b10;
  localparam logic [1:0] OkFault = 2'b11;

  localparam logic [1:0] OpIdle  = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FLT} state_t;

  state_t               state, stateNext;
  logic [CntW-1:0]      count, countNext;
  logic [ADDR_BITS-1:0] idxQ;
  logic                 isWriteQ;
  logic [LineW-1:0]     dataQ;
  logic [1:0]           memOKQ, memOKNext;
  logic [LineW-1:0]     memDataInQ;
  logic                 accept, loadRead, commitWrite, clearData;
  logic [AddrW-1:0]     offset, idxFull;
  logic                 inRange;
  logic [1:0]           opCode;
  logic                 unusedBits;

  logic [LineW-1:0]     ram [Lines];

  // Line index relative to BASE_ADDR; anything beyond the RAM (including wrap below base) faults.
  assign opCode     = bus.memOpm[4:3];
  assign offset     = bus.memAddr - BASE_ADDR;
  assign idxFull    = {4'b0000, offset[AddrW-1:4]};
  assign inRange    = (idxFull >> ADDR_BITS) == 32'd0;
  assign unusedBits = ^{bus.memOpm[2:0], offset[3:0]};

  assign bus.memOK     = memOKQ;
  assign bus.memDataIn = memDataInQ;

  // State and wait counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  // Next-state, counter and datapath strobes; memOK follows the next state.
  always_comb begin
    stateNext   = state;
    countNext   = count;
    accept      = 1'b0;
    loadRead    = 1'b0;
    commitWrite = 1'b0;
    clearData   = 1'b0;
    memOKNext   = OkReady;

    case (state)
      IDLE: begin
        if (opCode != OpIdle) begin
          accept = 1'b1;
          if ((opCode == OpRead || opCode == OpWrite) && inRange) begin
            stateNext = BUSY;
            countNext = CntW'(LATENCY - 1);
          end else begin
            stateNext = FLT;
            clearData = 1'b1;
          end
        end
      end
      BUSY: begin
        // Dropping the request aborts before anything touches the RAM.
        if (opCode == OpIdle) begin
          stateNext = IDLE;
        end else if (count == '0) begin
          stateNext = DONE;
          if (isWriteQ) commitWrite = 1'b1;
          else          loadRead    = 1'b1;
        end else begin
          countNext = count - CntW'(1);
        end
      end
      DONE: begin
        if (opCode == OpIdle) stateNext = IDLE;
      end
      FLT: begin
        if (opCode == OpIdle) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      BUSY:    memOKNext = OkHold;
      DONE:    memOKNext = OkDone;
      FLT:     memOKNext = OkFault;
      default: memOKNext = OkReady;
    endcase
  end

  // Registered outputs and request latches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      memOKQ     <= OkReady;
      memDataInQ <= '0;
      idxQ       <= '0;
      isWriteQ   <= 1'b0;
      dataQ      <= '0;
    end else begin
      memOKQ <= memOKNext;
      if (loadRead)       memDataInQ <= ram[idxQ];
      else if (clearData) memDataInQ <= '0;
      if (accept) begin
        idxQ     <= idxFull[ADDR_BITS-1:0];
        isWriteQ <= (opCode == OpWrite);
        dataQ    <= bus.memDataOut;
      end
    end
  end

  // Line RAM write port; contents survive reset, but no write lands while reset is held.
  always_ff @(posedge clock) begin
    if (reset && commitWrite) ram[idxQ] <= dataQ;
  end
endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: two instances (LATENCY 4 at base 0,
// LATENCY 1 with a 16-line RAM at base 0x1000), vector table plus corner sequences.
module tb_mem_line_responder;
  localparam logic [4:0] OPM_IDLE = 5'b00111;
  localparam logic [1:0] OP_RD = 2'b01, OP_WR = 2'b10, OP_RSV = 2'b11;
  localparam logic [1:0] K_RDY = 2'b00, K_OK = 2'b01, K_HOLD = 2'b10, K_FLT = 2'b11;

  localparam logic [127:0] V_DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_BEEF;
  localparam logic [127:0] V_L1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] V_V    = 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0;
  localparam logic [127:0] V_W    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] V_A    = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0001;
  localparam logic [127:0] V_A2   = 128'hAAAA_FFFF_AAAA_FFFF_AAAA_FFFF_AAAA_0002;
  localparam logic [127:0] V_B    = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
  localparam logic [127:0] V_C    = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [127:0] V_D0   = 128'hD0D0_D0D0_1234_1234_D0D0_D0D0_5678_5678;
  localparam logic [127:0] V_Z1   = 128'h2121_2121_2121_2121_2121_2121_2121_2121;
  localparam logic [127:0] V_Z2   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_line_responder_if bus0 ();
  mem_line_responder_if bus1 ();

  mem_line_responder #(.ADDR_BITS(10), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  mem_line_responder #(.ADDR_BITS(4), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    logic [1:0]   ok;
    logic [127:0] data;
    int           holds;
    bit           chk;
  } exp_t;

  typedef struct {
    int           sel;
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [1:0]   expOk;
    logic [127:0] expData;
    int           expHolds;
    bit           chk;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [1:0] getOk(input int sel);
    return (sel == 0) ? bus0.memOK : bus1.memOK;
  endfunction

  function automatic logic [127:0] getData(input int sel);
    return (sel == 0) ? bus0.memDataIn : bus1.memDataIn;
  endfunction

  task automatic drive(input int sel, input logic [4:0] opm, input logic [31:0] addr,
                       input logic [127:0] data);
    if (sel == 0) begin
      bus0.memOpm = opm; bus0.memAddr = addr; bus0.memDataOut = data;
    end else begin
      bus1.memOpm = opm; bus1.memAddr = addr; bus1.memDataOut = data;
    end
  endtask

  task automatic setOpm(input int sel, input logic [4:0] opm);
    if (sel == 0) bus0.memOpm = opm;
    else          bus1.memOpm = opm;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request (called at a negedge) and queue its expected response.
  task automatic start(input int sel, input logic [1:0] op, input logic [31:0] addr,
                       input logic [127:0] data, input logic [1:0] expOk,
                       input logic [127:0] expData, input int holds, input bit chk);
    exp_t e;
    e.ok = expOk; e.data = expData; e.holds = holds; e.chk = chk;
    sb.push_back(e);
    drive(sel, {op, 3'b011}, addr, data);
  endtask

  // Count HOLD cycles until OK/FAULT shows, then compare against the queued expectation.
  task automatic waitResp(input int sel, input string name);
    exp_t e;
    int holds;
    bit done;
    logic [1:0] ok;
    holds = 0;
    done  = 1'b0;
    ok    = K_RDY;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      ok = getOk(sel);
      if (ok == K_HOLD) holds++;
      else if (ok == K_OK || ok == K_FLT) done = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: memOK=%b after 40 cycles, expected %b", name, ok, e.ok);
    end else begin
      check({name, " memOK"}, 128'(ok), 128'(e.ok));
      check({name, " holds"}, 128'(holds), 128'(e.holds));
      if (e.chk) check({name, " data"}, getData(sel), e.data);
    end
  endtask

  // Response must persist while the request stays up, then return to READY after idle.
  task automatic finishTxn(input int sel, input string name, input logic [1:0] expOk);
    @(negedge clock);
    check({name, " held"}, 128'(getOk(sel)), 128'(expOk));
    setOpm(sel, OPM_IDLE);
    @(negedge clock);
    check({name, " ready"}, 128'(getOk(sel)), 128'(K_RDY));
  endtask

  task automatic runTxn(input int sel, input logic [1:0] op, input logic [31:0] addr,
                        input logic [127:0] data, input logic [1:0] expOk,
                        input logic [127:0] expData, input int holds, input bit chk,
                        input string name);
    start(sel, op, addr, data, expOk, expData, holds, chk);
    waitResp(sel, name);
    finishTxn(sel, name, expOk);
  endtask

  initial begin
    vecs[0]  = '{0, OP_WR,  32'h0000_0040, V_DEAD, K_OK,  '0,     4, 1'b0};
    vecs[1]  = '{0, OP_RD,  32'h0000_004C, '0,     K_OK,  V_DEAD, 4, 1'b1};
    vecs[2]  = '{0, OP_RD,  32'h0000_4000, '0,     K_FLT, '0,     0, 1'b1};
    vecs[3]  = '{0, OP_WR,  32'h0000_3FF0, V_L1,   K_OK,  '0,     4, 1'b0};
    vecs[4]  = '{0, OP_RD,  32'h0000_3FF5, '0,     K_OK,  V_L1,   4, 1'b1};
    vecs[5]  = '{0, OP_RSV, 32'h0000_0040, '0,     K_FLT, '0,     0, 1'b1};
    vecs[6]  = '{0, OP_RD,  32'h0000_0040, '0,     K_OK,  V_DEAD, 4, 1'b1};
    vecs[7]  = '{1, OP_WR,  32'h0000_1000, V_V,    K_OK,  '0,     1, 1'b0};
    vecs[8]  = '{1, OP_RD,  32'h0000_100C, '0,     K_OK,  V_V,    1, 1'b1};
    vecs[9]  = '{1, OP_WR,  32'h0000_10F0, V_W,    K_OK,  '0,     1, 1'b0};
    vecs[10] = '{1, OP_RD,  32'h0000_10F0, '0,     K_OK,  V_W,    1, 1'b1};
    vecs[11] = '{1, OP_RD,  32'h0000_1100, '0,     K_FLT, '0,     0, 1'b1};
    vecs[12] = '{1, OP_RD,  32'h0000_0FF0, '0,     K_FLT, '0,     0, 1'b1};
    vecs[13] = '{1, OP_RSV, 32'h0000_1000, '0,     K_FLT, '0,     0, 1'b1};
    vecs[14] = '{1, OP_RD,  32'h0000_1000, '0,     K_OK,  V_V,    1, 1'b1};

    // Reset held with a read request pending: no HOLD, outputs stay cleared.
    drive(0, {OP_RD, 3'b000}, 32'h0000_0040, '0);
    drive(1, {OP_RD, 3'b000}, 32'h0000_1000, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset memOK0", 128'(getOk(0)), 128'(K_RDY));
      check("reset data0", getData(0), '0);
      check("reset memOK1", 128'(getOk(1)), 128'(K_RDY));
    end
    reset = 1'b1;
    setOpm(0, OPM_IDLE);
    setOpm(1, OPM_IDLE);
    @(negedge clock);
    check("post-reset memOK0", 128'(getOk(0)), 128'(K_RDY));

    for (int i = 0; i < 15; i++) begin
      runTxn(vecs[i].sel, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].expOk,
             vecs[i].expData, vecs[i].expHolds, vecs[i].chk, $sformatf("vec%0d", i));
    end

    // Abort: dropping the request during the second HOLD cycle discards the write.
    runTxn(0, OP_WR, 32'h0000_0080, V_A, K_OK, '0, 4, 1'b0, "abort seed");
    drive(0, {OP_WR, 3'b000}, 32'h0000_0080, V_A2);
    @(negedge clock);
    check("abort hold1", 128'(getOk(0)), 128'(K_HOLD));
    @(negedge clock);
    check("abort hold2", 128'(getOk(0)), 128'(K_HOLD));
    setOpm(0, OPM_IDLE);
    @(negedge clock);
    check("abort ready", 128'(getOk(0)), 128'(K_RDY));
    runTxn(0, OP_RD, 32'h0000_0080, '0, K_OK, V_A, 4, 1'b1, "abort readback");

    // Address and data changes after acceptance are ignored.
    runTxn(0, OP_WR, 32'h0000_00D0, V_D0, K_OK, '0, 4, 1'b0, "latch seed");
    start(0, OP_WR, 32'h0000_00C0, V_B, K_OK, '0, 3, 1'b0);
    @(negedge clock);
    drive(0, {OP_WR, 3'b000}, 32'h0000_00D0, V_C);
    waitResp(0, "latch write");
    finishTxn(0, "latch write", K_OK);
    runTxn(0, OP_RD, 32'h0000_00C0, '0, K_OK, V_B, 4, 1'b1, "latch read C0");
    runTxn(0, OP_RD, 32'h0000_00D0, '0, K_OK, V_D0, 4, 1'b1, "latch read D0");

    // Reset in the middle of a write drops it.
    runTxn(0, OP_WR, 32'h0000_0200, V_Z1, K_OK, '0, 4, 1'b0, "rst seed");
    drive(0, {OP_WR, 3'b000}, 32'h0000_0200, V_Z2);
    @(negedge clock);
    @(negedge clock);
    check("rst mid hold", 128'(getOk(0)), 128'(K_HOLD));
    reset = 1'b0;
    @(negedge clock);
    check("rst mid memOK", 128'(getOk(0)), 128'(K_RDY));
    check("rst mid data", getData(0), '0);
    reset = 1'b1;
    setOpm(0, OPM_IDLE);
    @(negedge clock);
    check("rst mid idle", 128'(getOk(0)), 128'(K_RDY));
    runTxn(0, OP_RD, 32'h0000_0200, '0, K_OK, V_Z1, 4, 1'b1, "rst readback");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
